// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - single-outstanding load/store initiator with lane steering and word-crossing split
module load_store_unit #(
    parameter int SUPPORT_MISALIGNED = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_error,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    output logic        mem_write_enable,
    output logic [3:0]  mem_byte_enable,
    input  logic [31:0] mem_read_data
);

    typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_t;

    state_t      state, state_nx;
    logic        write_q, uns_q, err_q;
    logic [1:0]  size_q;
    logic [31:0] addr_q, wdata_q, lo_q, hi_q;

    logic        accept, misaligned, req_error;
    logic [3:0]  size_mask;
    logic [7:0]  lane_mask;
    logic [63:0] lane_data;
    logic [31:0] load_word, load_ext;
    logic [31:0] word_addr;

    assign accept     = req_valid && req_ready;
    assign misaligned = (req_size == 2'b01 && req_addr[0]) ||
                        (req_size == 2'b10 && req_addr[1:0] != 2'b00);
    assign req_error  = (req_size == 2'b11) || (SUPPORT_MISALIGNED == 0 && misaligned);
    assign word_addr  = {addr_q[31:2], 2'b00};

    // An 8-lane mask/64-bit data window spans the addressed word and the next one.
    always_comb begin
        case (size_q)
            2'b00:   size_mask = 4'b0001;
            2'b01:   size_mask = 4'b0011;
            default: size_mask = 4'b1111;
        endcase
        lane_mask = {4'b0000, size_mask} << addr_q[1:0];
        lane_data = {32'd0, wdata_q} << {addr_q[1:0], 3'b000};
        load_word = 32'({hi_q, lo_q} >> {addr_q[1:0], 3'b000});
        case (size_q)
            2'b00:   load_ext = uns_q ? {24'd0, load_word[7:0]}
                                      : {{24{load_word[7]}}, load_word[7:0]};
            2'b01:   load_ext = uns_q ? {16'd0, load_word[15:0]}
                                      : {{16{load_word[15]}}, load_word[15:0]};
            default: load_ext = load_word;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            write_q <= 1'b0;
            uns_q   <= 1'b0;
            err_q   <= 1'b0;
            size_q  <= 2'b00;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            lo_q    <= 32'd0;
            hi_q    <= 32'd0;
        end else begin
            state <= state_nx;
            if (accept) begin
                write_q <= req_write;
                uns_q   <= req_unsigned;
                err_q   <= req_error;
                size_q  <= req_size;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                lo_q    <= 32'd0;
                hi_q    <= 32'd0;
            end
            if (state == ACC0 && !write_q) lo_q <= mem_read_data;
            if (state == ACC1 && !write_q) hi_q <= mem_read_data;
        end
    end

    always_comb begin
        state_nx         = state;
        req_ready        = (state == IDLE) && rst_n;
        resp_valid       = 1'b0;
        resp_rdata       = 32'd0;
        resp_error       = 1'b0;
        mem_address      = 32'd0;
        mem_write_data   = 32'd0;
        mem_write_enable = 1'b0;
        mem_byte_enable  = 4'b0000;
        case (state)
            IDLE: begin
                if (accept) state_nx = req_error ? RESP : ACC0;
            end
            ACC0: begin
                mem_address      = word_addr;
                mem_byte_enable  = lane_mask[3:0];
                mem_write_data   = lane_data[31:0];
                mem_write_enable = write_q;
                state_nx         = (lane_mask[7:4] != 4'b0000) ? ACC1 : RESP;
            end
            ACC1: begin
                mem_address      = word_addr + 32'd4;
                mem_byte_enable  = lane_mask[7:4];
                mem_write_data   = lane_data[63:32];
                mem_write_enable = write_q;
                state_nx         = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                resp_error = err_q;
                resp_rdata = (err_q || write_q) ? 32'd0 : load_ext;
                state_nx   = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Initiator side of the main memory data port. Accepts one load or store at a time from the pipeline's memory stage over a valid/ready handshake and drives word-addressed memory accesses with byte enables. Shifts store data into lane position and aligns, sign- or zero-extends load data. Accesses that straddle a word boundary are split into two consecutive word accesses.

## Interface
- `SUPPORT_MISALIGNED`, default 1: 1 = misaligned accesses are executed (split if crossing a word); 0 = any misaligned access returns an error with no memory access.
- `clk` in 1: clock; all state updates on the rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `req_valid` in 1: request present.
- `req_ready` out 1: high only in IDLE with `rst_n` high.
- `req_write` in 1: 1 = store, 0 = load.
- `req_size` in 2: 00 byte, 01 half, 10 word, 11 reserved (error).
- `req_unsigned` in 1: loads only; 1 = zero-extend, 0 = sign-extend.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, right-aligned.
- `resp_valid` out 1: single-cycle completion pulse; no backpressure.
- `resp_rdata` out 32: extended load data; 0 for stores and errors.
- `resp_error` out 1: valid with `resp_valid`.
- `mem_address` out 32: word-aligned address, bits [1:0] always 00.
- `mem_write_data` out 32: lane-positioned store data.
- `mem_write_enable` out 1: memory commits on the rising edge ending the cycle.
- `mem_byte_enable` out 4: lane mask.
- `mem_read_data` in 32: combinational read of `mem_address`, valid in the same cycle.

## Operation
- States: IDLE, ACC0, ACC1, RESP.
- **IDLE:**
  - `req_valid && req_ready` latches all `req_*` fields.
  - Error: `req_size==11`, or `SUPPORT_MISALIGNED==0` with `addr` not a multiple of the size. Next state is RESP with the error flag set.
  - Otherwise next state is ACC0.
- **Masks and data:**
  - off = `addr[1:0]`; size mask m = 0001, 0011 or 1111; 8-bit mask M = m << off.
  - W = `wdata` zero-extended to 64 bits, then shifted left by 8*off.
- **ACC0:**
  - `mem_address` = {`addr[31:2]`,00}; `mem_byte_enable` = M[3:0]; `mem_write_data` = W[31:0]; `mem_write_enable` = `req_write`.
  - Loads capture `mem_read_data` into lo.
  - Next state is ACC1 if M[7:4]≠0, else RESP.
- **ACC1:**
  - `mem_address` = ACC0 address + 4, mod 2^32 (0xFFFFFFFC wraps to 0x00000000); `mem_byte_enable` = M[7:4]; `mem_write_data` = W[63:32].
  - Loads capture hi. Next state is RESP.
- **RESP:**
  - `resp_valid`=1.
  - Loads: r = ({hi,lo} >> 8*off)[31:0], with hi=0 if ACC1 was skipped. Byte/half results are extended from bit 7/15 per `req_unsigned`.
  - Next state is IDLE.
- Outside ACC0/ACC1: `mem_write_enable`=0, `mem_byte_enable`=0, `mem_address`=0, `mem_write_data`=0.
- Split stores are not atomic: the ACC0 part is committed before ACC1.

## Timing
- Reset values: state IDLE, `req_ready`=0 while `rst_n` low, `resp_valid`=0, `resp_rdata`=0, `resp_error`=0, all `mem_*` outputs 0, internal registers 0.
- Accept at edge T:
  - Non-crossing access: ACC0 during cycle T+1; `resp_valid` during T+2.
  - Crossing access: `resp_valid` during T+3.
  - Error: `resp_valid` during T+1, no memory cycle.
- `req_ready` is low from the cycle after accept through RESP. The next accept is possible at the earliest in the cycle after RESP.
- Throughput: one aligned access per 3 cycles.
- `resp_rdata`/`resp_error` are meaningful only while `resp_valid`=1 and are 0 otherwise.
- Reset mid-operation:
  - `rst_n` falling forces all outputs to their reset values immediately and returns the state to IDLE.
  - A memory write whose cycle is cut by reset before its edge is not committed.
  - No response is generated for the aborted request.
- `req_*` inputs are ignored when `req_ready`=0.

## Test plan
- Aligned word store then load:
  - Store 0xDEADBEEF at 0x100: ACC0 shows `mem_address`=0x100, be=1111, `mem_write_enable`=1.
  - Load word at 0x100: `resp_rdata`=0xDEADBEEF, `resp_valid` 2 cycles after accept.
- Byte/half extension, with mem[0x200]=0x80FF7F01:
  - lb 0x203 → 0xFFFFFF80; lbu 0x203 → 0x00000080.
  - lh 0x200 → 0x00007F01; lhu 0x202 → 0x000080FF.
- Sub-word store: sb 0xAB at 0x301 → be=0010, `mem_write_data`=0x0000AB00; word 0x300 changes only in bits [15:8].
- Crossing word load, mem[0x400]=0x44332211, mem[0x404]=0x88776655:
  - lw 0x403 → two accesses, 0x400 with be=1000 then 0x404 with be=0111.
  - `resp_rdata`=0x77665544; `resp_valid` 3 cycles after accept.
- Errors:
  - `req_size`=11: `resp_error`=1 one cycle after accept, no `mem_write_enable`.
  - With `SUPPORT_MISALIGNED`=0, lw 0x402: `resp_error`=1, `resp_rdata`=0.
- Reset during the ACC1 of a crossing sw at 0xFFFFFFFE:
  - Before reset, ACC1 address=0x00000000 (wrap).
  - Asserting `rst_n`=0 in ACC1 drops `mem_write_enable` immediately, word 0x0 is unchanged, and no `resp_valid` is generated.
